instr_loader: RTL and testbench

Boot-time program loader that produces the instruction words the core's fetch/decode path later consumes. It receives a byte stream from the UART receiver, assembles little-endian 32-bit words, and writes them sequentially into instruction memory from word address 0. It holds the core in reset until loading completes. On completion or overflow it emits a one-byte acknowledge to the UART transmitter.

---
 rtl/loader_pkg.sv | 17 +
 rtl/word_assembler.sv | 60 ++++++
 rtl/instr_loader.sv | 144 ++++++++++++++
 tb/tb_instr_loader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: types and constants shared by the instruction loader.
//   state_t : loader phase (header, payload, finished, rejected)
//   ACK_OK  : acknowledge byte sent after a successful load
//   ACK_ERR : acknowledge byte sent when the declared length is too large
package loader_pkg;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        BODY = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [7:0] ACK_OK  = 8'hAA;
    localparam logic [7:0] ACK_ERR = 8'h55;

endpackage

// File: rtl/word_assembler.sv
// word_assembler: packs a byte stream into little-endian 32-bit words.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   i_byte_valid   a byte is offered this cycle
//   i_byte         the offered byte
//   o_word_valid   registered, one cycle after the edge taking the 4th byte
//   o_word         registered, the completed word
//   o_last         combinational: the offered byte completes a word
//   o_next_word    combinational: the word as it will be once this byte lands
// o_last/o_next_word let the parent act on the same edge that completes a
// word, so its own registered outputs line up with o_word_valid.
module word_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word,
    output logic        o_last,
    output logic [31:0] o_next_word
);

    logic [1:0]  r_cnt;
    logic [31:0] r_shift;
    logic        r_word_valid;
    logic [31:0] r_word;

    // New bytes enter at the top so the first byte of a word ends in [7:0].
    assign o_next_word  = {i_byte, r_shift[31:8]};
    assign o_last       = i_byte_valid && (r_cnt == 2'd3);
    assign o_word_valid = r_word_valid;
    assign o_word       = r_word;

    // Byte counter, shift register and completed-word capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= 2'd0;
            r_shift      <= 32'd0;
            r_word_valid <= 1'b0;
            r_word       <= 32'd0;
        end else begin
            r_word_valid <= 1'b0;
            if (i_byte_valid) begin
                r_shift <= o_next_word;
                r_cnt   <= r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                    r_word_valid <= 1'b1;
                    r_word       <= o_next_word;
                end else begin
                    r_word <= r_word;
                end
            end else begin
                r_shift <= r_shift;
            end
        end
    end

endmodule

// File: rtl/instr_loader.sv
// instr_loader: boot loader writing a UART byte stream into instruction
// memory. Stream = 4-byte little-endian word count N, then N little-endian
// words written to addresses 0..N-1. Holds the core in reset until done.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rx_valid, rx_data        received byte strobe and data
//   imem_we/addr/wdata       instruction-memory write (one-cycle pulse)
//   tx_valid, tx_data        acknowledge byte strobe (AA ok, 55 error)
//   core_hold                high while the core must stay in reset
//   done, err                sticky completion / length-error flags
module instr_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    output logic              core_hold,
    output logic              done,
    output logic              err
);

    // Capacity in words; 33 bits so the full 32-bit header compares cleanly.
    localparam logic [32:0] CAP = 33'd1 << ADDR_W;

    state_t              r_state;
    logic [ADDR_W:0]     r_n;
    logic [ADDR_W:0]     r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_imem_addr;
    logic                r_body_wr;
    logic                r_tx_valid;
    logic [7:0]          r_tx_data;
    logic                r_core_hold;
    logic                r_done;
    logic                r_err;

    logic                w_accept;
    logic                w_word_valid;
    logic [31:0]         w_word;
    logic                w_last;
    logic [31:0]         w_next_word;

    // Bytes are only consumed while the header or payload is being read.
    assign w_accept = rx_valid && ((r_state == HDR) || (r_state == BODY));

    word_assembler u_asm (
        .clk          (clk),
        .rst          (rst),
        .i_byte_valid (w_accept),
        .i_byte       (rx_data),
        .o_word_valid (w_word_valid),
        .o_word       (w_word),
        .o_last       (w_last),
        .o_next_word  (w_next_word)
    );

    // A header word also raises w_word_valid, so the write strobe is
    // qualified by r_body_wr, set only for payload words.
    assign imem_we    = w_word_valid && r_body_wr;
    assign imem_addr  = r_imem_addr;
    assign imem_wdata = w_word;
    assign tx_valid   = r_tx_valid;
    assign tx_data    = r_tx_data;
    assign core_hold  = r_core_hold;
    assign done       = r_done;
    assign err        = r_err;

    // Loader FSM with registered control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HDR;
            r_n         <= '0;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_imem_addr <= '0;
            r_body_wr   <= 1'b0;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= 8'h00;
            r_core_hold <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_tx_valid <= 1'b0;
            r_body_wr  <= 1'b0;
            case (r_state)
                HDR: begin
                    if (w_last) begin
                        if (w_next_word == 32'd0) begin
                            r_state     <= DONE;
                            r_done      <= 1'b1;
                            r_core_hold <= 1'b0;
                            r_tx_valid  <= 1'b1;
                            r_tx_data   <= ACK_OK;
                        end else if ({1'b0, w_next_word} > CAP) begin
                            r_state    <= ERR;
                            r_err      <= 1'b1;
                            r_tx_valid <= 1'b1;
                            r_tx_data  <= ACK_ERR;
                        end else begin
                            r_state <= BODY;
                            r_n     <= w_next_word[ADDR_W:0];
                            r_cnt   <= '0;
                            r_addr  <= '0;
                        end
                    end else begin
                        r_state <= HDR;
                    end
                end
                BODY: begin
                    if (w_last) begin
                        r_body_wr   <= 1'b1;
                        r_imem_addr <= r_addr;
                        // Wraps only after the final write of a full load.
                        r_addr      <= r_addr + ADDR_W'(1);
                        r_cnt       <= r_cnt + (ADDR_W + 1)'(1);
                        if ((r_cnt + (ADDR_W + 1)'(1)) == r_n) begin
                            r_state     <= DONE;
                            r_done      <= 1'b1;
                            r_core_hold <= 1'b0;
                            r_tx_valid  <= 1'b1;
                            r_tx_data   <= ACK_OK;
                        end else begin
                            r_state <= BODY;
                        end
                    end else begin
                        r_state <= BODY;
                    end
                end
                DONE:    r_state <= DONE;
                ERR:     r_state <= ERR;
                default: r_state <= HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

    localparam int TB_ADDR_W = 4;
    localparam int TB_CAP    = 16;

    typedef logic [7:0] bq_t[$];

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 rx_valid = 1'b0;
    logic [7:0]           rx_data = 8'h00;
    logic                 imem_we;
    logic [TB_ADDR_W-1:0] imem_addr;
    logic [31:0]          imem_wdata;
    logic                 tx_valid;
    logic [7:0]           tx_data;
    logic                 core_hold;
    logic                 done;
    logic                 err;

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc       = 0;

    // monitor records
    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    logic [7:0]  tx_q[$];
    int          tx_cyc_q[$];
    int          done_cyc = -1;
    int          err_cyc  = -1;
    int          drv_q[$];

    instr_loader #(.ADDR_W(TB_ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .core_hold  (core_hold),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr_q.push_back(int'(imem_addr));
            wr_data_q.push_back(imem_wdata);
            wr_cyc_q.push_back(cyc);
        end
        if (tx_valid === 1'b1) begin
            tx_q.push_back(tx_data);
            tx_cyc_q.push_back(cyc);
        end
        if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
        if (err === 1'b1 && err_cyc < 0) err_cyc = cyc;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        tx_q.delete();
        tx_cyc_q.delete();
        done_cyc = -1;
        err_cyc  = -1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_mon();
        @(negedge clk);
        check("rst_we", imem_we, 1'b0);
        check("rst_addr", imem_addr, 0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_core_hold", core_hold, 1'b1);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
    endtask

    task automatic send_bytes(input bq_t b, input int gap_max);
        int gap;
        drv_q.delete();
        for (int i = 0; i < b.size(); i++) begin
            @(posedge clk); #1;
            rx_valid = 1'b1;
            rx_data  = b[i];
            drv_q.push_back(cyc);
            gap = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
            end
        end
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
    endtask

    function automatic bq_t mk_stream(input logic [31:0] n, input int nwords, input int extra);
        bq_t q;
        logic [31:0] w;
        for (int k = 0; k < 4; k++) q.push_back(8'(n >> (8 * k)));
        for (int i = 0; i < nwords; i++) begin
            w = $urandom;
            for (int k = 0; k < 4; k++) q.push_back(8'(w >> (8 * k)));
        end
        for (int i = 0; i < extra; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    // Reference: decode the byte stream by the loader's rules and compare
    // with everything the monitor saw since reset.
    task automatic check_stream(input string tag, input bq_t b);
        logic [31:0] n;
        logic [31:0] w;
        bit          is_err;
        int          nw;
        int          last_idx;
        int          exp_cyc;
        n = {b[3], b[2], b[1], b[0]};
        is_err = (n > 32'(TB_CAP));
        nw = is_err ? 0 : int'(n);
        last_idx = (nw == 0) ? 3 : 4 * nw + 3;
        exp_cyc = drv_q[last_idx] + 1;
        check({tag, "_we_count"}, wr_addr_q.size(), nw);
        for (int i = 0; i < nw; i++) begin
            w = {b[4 + 4*i + 3], b[4 + 4*i + 2], b[4 + 4*i + 1], b[4 + 4*i]};
            if (i < wr_addr_q.size()) begin
                check({tag, "_addr"}, wr_addr_q[i], i);
                check({tag, "_wdata"}, wr_data_q[i], w);
            end
        end
        if (nw > 0 && wr_cyc_q.size() == nw)
            check({tag, "_last_we_cyc"}, wr_cyc_q[nw-1], exp_cyc);
        check({tag, "_done"}, done, !is_err);
        check({tag, "_err"}, err, is_err);
        check({tag, "_core_hold"}, core_hold, is_err);
        check({tag, "_tx_count"}, tx_q.size(), 1);
        if (tx_q.size() > 0) begin
            check({tag, "_tx_data"}, tx_q[0], is_err ? 8'h55 : 8'hAA);
            check({tag, "_tx_cyc"}, tx_cyc_q[0], exp_cyc);
        end
        if (is_err) check({tag, "_err_cyc"}, err_cyc, exp_cyc);
        else        check({tag, "_done_cyc"}, done_cyc, exp_cyc);
    endtask

    initial begin
        bq_t s;
        bq_t part;

        // directed: N=2 example program
        do_reset();
        s = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
              8'h93, 8'h05, 8'h20, 8'h00};
        send_bytes(s, 2);
        check_stream("n2", s);

        // header only, N=0
        do_reset();
        s = mk_stream(32'd0, 0, 0);
        send_bytes(s, 1);
        check_stream("n0", s);

        // N=17 exceeds capacity; a further 4-byte stream must be ignored
        do_reset();
        s = mk_stream(32'd17, 0, 4);
        send_bytes(s, 1);
        check_stream("n17", s);

        // full capacity, back-to-back bytes
        do_reset();
        s = mk_stream(32'd16, 16, 0);
        send_bytes(s, 0);
        check_stream("n16", s);
        if (wr_addr_q.size() == 16) check("n16_last_addr", wr_addr_q[15], 15);

        // large header whose low bits look legal must still be rejected
        do_reset();
        s = mk_stream(32'h1000_0003, 0, 8);
        send_bytes(s, 0);
        check_stream("nbig", s);

        // reset mid-load, then a clean N=1 load
        do_reset();
        s = mk_stream(32'd3, 3, 0);
        part = s[0:5];
        send_bytes(part, 0);
        check("partial_no_we", wr_addr_q.size(), 0);
        check("partial_hold", core_hold, 1'b1);
        do_reset();
        s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_bytes(s, 1);
        check_stream("after_rst", s);
        if (wr_data_q.size() > 0) check("after_rst_word", wr_data_q[0], 32'hDEADBEEF);

        // extra bytes after DONE are ignored
        do_reset();
        s = mk_stream(32'd1, 1, 9);
        send_bytes(s, 1);
        check_stream("extra", s);

        // randomized loads
        for (int r = 0; r < 6; r++) begin
            do_reset();
            s = mk_stream(32'($urandom_range(TB_CAP, 1)), 0, 0);
            s = mk_stream({s[3], s[2], s[1], s[0]}, int'({s[3], s[2], s[1], s[0]}),
                          $urandom_range(5, 0));
            send_bytes(s, $urandom_range(2, 0));
            check_stream("rand", s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
